rggen_bus_arbiter: RTL and testbench

- Shares one downstream rggen register bus between REQUESTERS upstream masters using round-robin arbitration.
- The downstream bus typically drives a protocol bridge, e.g. the AXI4-Lite or APB bridge.
- A grant is registered and locked until the downstream bus completes, so each upstream transfer reaches the bridge unchanged.

---
 rtl/rggen_rtl_pkg.sv | 19 +
 rtl/rggen_bus_if.sv | 41 ++++
 rtl/rggen_round_robin_arbiter.sv | 32 +++
 rtl/rggen_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_rtl_pkg.sv
// rggen register bus common types.
// Access kinds and response status shared by bus components.
package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b10,
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  localparam int RGGEN_ACCESS_DATA_BIT       = 0;
  localparam int RGGEN_ACCESS_NON_POSTED_BIT = 1;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage

// File: rtl/rggen_bus_if.sv
// rggen register bus: one request channel, one response.
// master drives valid/access/address/write_data/strobe.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  import rggen_rtl_pkg::*;

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid,
    output access,
    output address,
    output write_data,
    output strobe,
    input  ready,
    input  status,
    input  read_data
  );

  modport slave (
    input  valid,
    input  access,
    input  address,
    input  write_data,
    input  strobe,
    output ready,
    output status,
    output read_data
  );
endinterface

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin pick: i_request, i_pointer
// in; one-hot o_grant searching upward from pointer.
module rggen_round_robin_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_request,
  input  logic [PW-1:0] i_pointer,
  output logic [N-1:0]  o_grant
);
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk downward so the closest requester at or
  // above the pointer overwrites any farther one.
  always_comb begin
    o_grant = '0;
    sum     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, i_pointer} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(N)) begin
        sum = sum - (PW + 1)'(N);
      end
      idx = sum[PW-1:0];
      if (i_request[idx]) begin
        o_grant      = '0;
        o_grant[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin share of one rggen bus by REQUESTERS masters.
// i_* per-requester request, o_* per-requester reply, bus_if.
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32,
  localparam int STROBE_WIDTH = BUS_WIDTH / 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [REQUESTERS-1:0]                i_valid,
  input  logic [REQUESTERS*2-1:0]              i_access,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]  i_address,
  input  logic [REQUESTERS*BUS_WIDTH-1:0]      i_write_data,
  input  logic [REQUESTERS*STROBE_WIDTH-1:0]   i_strobe,
  output logic [REQUESTERS-1:0]                o_ready,
  output logic [REQUESTERS*2-1:0]              o_status,
  output logic [REQUESTERS*BUS_WIDTH-1:0]      o_read_data,
  rggen_bus_if.master                          bus_if
);
  localparam int N  = REQUESTERS;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = BUS_WIDTH;
  localparam int SW = STROBE_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state;
  logic [N-1:0]  grant;
  logic [N-1:0]  winner;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] next_ptr;
  logic          busy;
  logic          done;

  logic [1:0]    mux_access;
  logic [AW-1:0] mux_address;
  logic [DW-1:0] mux_write_data;
  logic [SW-1:0] mux_strobe;

  rggen_round_robin_arbiter #(
    .N (N)
  ) u_rr (
    .i_request (i_valid),
    .i_pointer (ptr),
    .o_grant   (winner)
  );

  assign busy = (state == BUSY);
  assign done = busy && bus_if.ready;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_idx = PW'(i);
      end
    end
  end

  // Explicit wrap keeps non-power-of-2 counts correct;
  // with one requester this is always zero.
  assign next_ptr =
    (grant_idx == PW'(N - 1)) ? '0
                              : grant_idx + PW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|i_valid) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus_if.ready) begin
            grant <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // grant is all-zero outside BUSY, so the AND-OR mux
  // also yields the zeroed request fields in IDLE.
  always_comb begin
    mux_access     = '0;
    mux_address    = '0;
    mux_write_data = '0;
    mux_strobe     = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        mux_access     = mux_access
                       | i_access[2*i+:2];
        mux_address    = mux_address
                       | i_address[AW*i+:AW];
        mux_write_data = mux_write_data
                       | i_write_data[DW*i+:DW];
        mux_strobe     = mux_strobe
                       | i_strobe[SW*i+:SW];
      end
    end
  end

  assign bus_if.valid      = busy;
  assign bus_if.access     = rggen_access'(mux_access);
  assign bus_if.address    = mux_address;
  assign bus_if.write_data = mux_write_data;
  assign bus_if.strobe     = mux_strobe;

  always_comb begin
    o_ready     = '0;
    o_status    = '0;
    o_read_data = '0;
    for (int i = 0; i < N; i++) begin
      if (done && grant[i]) begin
        o_ready[i]              = 1'b1;
        o_status[2*i+:2]        = bus_if.status;
        o_read_data[DW*i+:DW]   = bus_if.read_data;
      end
    end
  end
endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Bench for rggen_bus_arbiter with three requesters.
// Directed scenarios plus random traffic vs a model.
module tb_rggen_bus_arbiter;
  import rggen_rtl_pkg::*;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int BW = 1 + 2 + AW + DW + SW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      valid;
  logic [N*2-1:0]    access;
  logic [N*AW-1:0]   address;
  logic [N*DW-1:0]   wdata;
  logic [N*SW-1:0]   strobe;
  logic [N-1:0]      ready;
  logic [N*2-1:0]    status;
  logic [N*DW-1:0]   rdata;

  int total = 0;
  int bad   = 0;

  rggen_bus_if #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (DW)
  ) bus ();

  rggen_bus_arbiter #(
    .REQUESTERS    (N),
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (DW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_access     (access),
    .i_address    (address),
    .i_write_data (wdata),
    .i_strobe     (strobe),
    .o_ready      (ready),
    .o_status     (status),
    .o_read_data  (rdata),
    .bus_if       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] bus_now();
    return {bus.valid, bus.access, bus.address,
            bus.write_data, bus.strobe};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(
    input int            i,
    input logic          v,
    input logic [1:0]    a,
    input logic [AW-1:0] ad,
    input logic [DW-1:0] wd,
    input logic [SW-1:0] s
  );
    valid[i]          = v;
    access[2*i+:2]    = a;
    address[AW*i+:AW] = ad;
    wdata[DW*i+:DW]   = wd;
    strobe[SW*i+:SW]  = s;
  endtask

  task automatic idle_all();
    valid   = '0;
    access  = '0;
    address = '0;
    wdata   = '0;
    strobe  = '0;
  endtask

  task automatic set_bus(
    input logic          r,
    input logic [1:0]    st,
    input logic [DW-1:0] rd
  );
    bus.ready     = r;
    bus.status    = rggen_status'(st);
    bus.read_data = rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    set_bus(1'b0, RGGEN_OKAY, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = '1;
    set_bus(1'b1, RGGEN_SLAVE_ERROR, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus_now() !== '0) begin
      bad++;
      $display("FAIL reset_bus got=%h want=0",
               bus_now());
    end
    total++;
    if ({ready, status, rdata} !== '0) begin
      bad++;
      $display("FAIL reset_out got=%b/%h/%h want=0",
               ready, status, rdata);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(1, 1'b1, RGGEN_READ, 16'h0010, '0, '0);
    set_bus(1'b1, RGGEN_OKAY, 32'hDEAD_BEEF);
    @(negedge clk);
    total++;
    if (bus.valid !== 1'b0 || ready !== '0) begin
      bad++;
      $display("FAIL read_c0 valid=%b rdy=%b want 0/0",
               bus.valid, ready);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus_now() !== {1'b1, RGGEN_READ,
                       16'h0010, 32'h0, 4'h0}) begin
      bad++;
      $display("FAIL read_bus got=%h", bus_now());
    end
    total++;
    if (ready !== 3'b010 ||
        rdata !== {32'h0, 32'hDEAD_BEEF, 32'h0} ||
        status !== '0) begin
      bad++;
      $display("FAIL read_resp rdy=%b data=%h st=%b",
               ready, rdata, status);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    total++;
    if (bus.valid !== 1'b0 || ready !== '0) begin
      bad++;
      $display("FAIL read_c2 valid=%b rdy=%b want 0/0",
               bus.valid, ready);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, RGGEN_READ,
              AW'(16'h0100 + i), '0, '0);
    end
    set_bus(1'b1, RGGEN_OKAY, 32'h5A5A_0000);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (ready !== N'(1 << (k % N)) ||
          bus.address !== AW'(16'h0100 + k % N)) begin
        bad++;
        $display("FAIL rr_%0d rdy=%b adr=%h want %0d",
                 k, ready, bus.address, k % N);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (bus.valid !== 1'b0 || ready !== '0) begin
        bad++;
        $display("FAIL rr_bubble_%0d valid=%b rdy=%b",
                 k, bus.valid, ready);
      end
    end
    idle_all();
  endtask

  task automatic test_hold();
    logic [BW-1:0] want;
    do_reset();
    set_req(0, 1'b1, RGGEN_WRITE, 16'h0004,
            32'h1234_5678, 4'hF);
    set_bus(1'b0, RGGEN_OKAY, '0);
    want = {1'b1, RGGEN_WRITE, 16'h0004,
            32'h1234_5678, 4'hF};
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      if (c == 3) begin
        set_req(2, 1'b1, RGGEN_READ, 16'h0020,
                '0, '0);
      end
      if (c == 11) begin
        set_bus(1'b1, RGGEN_OKAY, '0);
      end
      @(negedge clk);
      total++;
      if (bus_now() !== want ||
          ready !== ((c == 11) ? 3'b001 : 3'b000)) begin
        bad++;
        $display("FAIL hold_%0d bus=%h rdy=%b",
                 c, bus_now(), ready);
      end
    end
    next_cycle();
    valid[0] = 1'b0;
    set_bus(1'b1, RGGEN_OKAY, 32'hCAFE_0002);
    @(negedge clk);
    total++;
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_bubble valid=%b want 0",
               bus.valid);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus.address !== 16'h0020 || ready !== 3'b100 ||
        rdata[2*DW+:DW] !== 32'hCAFE_0002) begin
      bad++;
      $display("FAIL hold_next adr=%h rdy=%b want 0020/100",
               bus.address, ready);
    end
    next_cycle();
    idle_all();
  endtask

  task automatic test_error();
    do_reset();
    set_req(1, 1'b1, RGGEN_WRITE, 16'h0008,
            32'h0000_00AA, 4'h1);
    set_bus(1'b1, RGGEN_SLAVE_ERROR, '0);
    next_cycle();
    @(negedge clk);
    total++;
    if (status !== 6'b00_10_00 || ready !== 3'b010) begin
      bad++;
      $display("FAIL err_status got=%b/%b want 001000/010",
               status, ready);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    total++;
    if (status !== '0) begin
      bad++;
      $display("FAIL err_once got=%b want 0", status);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1, 1'b1, RGGEN_READ, 16'h0030, '0, '0);
    set_bus(1'b0, RGGEN_OKAY, '0);
    next_cycle();
    @(negedge clk);
    total++;
    if (bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL ares_busy valid=%b want 1",
               bus.valid);
    end
    #2;
    rst_n = 1'b0;
    set_bus(1'b1, RGGEN_OKAY, 32'h1111_2222);
    #1;
    total++;
    if (bus.valid !== 1'b0 || ready !== '0) begin
      bad++;
      $display("FAIL ares_drop valid=%b rdy=%b want 0/0",
               bus.valid, ready);
    end
    next_cycle();
    rst_n = 1'b1;
    set_req(0, 1'b1, RGGEN_READ, 16'h0040, '0, '0);
    next_cycle();
    @(negedge clk);
    total++;
    if (ready !== 3'b001 || bus.address !== 16'h0040) begin
      bad++;
      $display("FAIL ares_after rdy=%b adr=%h want 001/0040",
               ready, bus.address);
    end
    next_cycle();
    idle_all();
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(1, 1'b1, RGGEN_READ, 16'h0050, '0, '0);
    set_bus(1'b1, RGGEN_OKAY, '0);
    next_cycle();
    next_cycle();
    set_req(0, 1'b1, RGGEN_READ, 16'h0060, '0, '0);
    next_cycle();
    @(negedge clk);
    total++;
    if (ready !== 3'b001 || bus.address !== 16'h0060) begin
      bad++;
      $display("FAIL wrap_first rdy=%b adr=%h want 001",
               ready, bus.address);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if (ready !== 3'b010 || bus.address !== 16'h0050) begin
      bad++;
      $display("FAIL wrap_second rdy=%b adr=%h want 010",
               ready, bus.address);
    end
    next_cycle();
    idle_all();
  endtask

  task automatic test_random();
    int            owner;
    int            ptr;
    logic [N-1:0]  pending;
    logic [BW-1:0] exp_bus;
    logic [N-1:0]  exp_rdy;
    logic [N*2-1:0]  exp_st;
    logic [N*DW-1:0] exp_rd;
    do_reset();
    owner   = -1;
    ptr     = 0;
    pending = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i]) begin
          set_req(i, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 1)
                    ? RGGEN_WRITE : RGGEN_READ,
                  AW'($urandom), DW'($urandom),
                  SW'($urandom));
          pending[i] = valid[i];
        end
      end
      set_bus(($urandom_range(0, 1) == 1),
              2'($urandom), DW'($urandom));
      @(negedge clk);
      exp_bus = '0;
      exp_rdy = '0;
      exp_st  = '0;
      exp_rd  = '0;
      if (owner >= 0) begin
        exp_bus = {1'b1, access[2*owner+:2],
                   address[AW*owner+:AW],
                   wdata[DW*owner+:DW],
                   strobe[SW*owner+:SW]};
        if (bus.ready) begin
          exp_rdy[owner]         = 1'b1;
          exp_st[2*owner+:2]     = bus.status;
          exp_rd[DW*owner+:DW]   = bus.read_data;
        end
      end
      total++;
      if (bus_now() !== exp_bus) begin
        bad++;
        $display("FAIL rnd_bus_%0d got=%h want=%h",
                 cyc, bus_now(), exp_bus);
      end
      total++;
      if ({ready, status, rdata} !==
          {exp_rdy, exp_st, exp_rd}) begin
        bad++;
        $display("FAIL rnd_resp_%0d rdy=%b want=%b st=%b want=%b",
                 cyc, ready, exp_rdy, status, exp_st);
      end
      if (owner >= 0) begin
        if (bus.ready) begin
          pending[owner] = 1'b0;
          ptr   = (owner + 1) % N;
          owner = -1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (owner < 0 && valid[(ptr + k) % N]) begin
            owner = (ptr + k) % N;
          end
        end
      end
      next_cycle();
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    set_bus(1'b0, RGGEN_OKAY, '0);
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold();
    test_error();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
